i2c_gpio_port: RTL and testbench

- I2C-addressable 8-bit GPIO peripheral. Consumes the shared i2c_frontend bus bundle (rx) and drives its reply bundle (tx), alongside the existing pwm_i2c LED slave.
- Exposes a small register file through a register pointer: output latch, direction, synchronized input, ID.
- The top level ORs tx from all slaves before returning it to the frontend.

---
 rtl/i2c_bus_pkg.sv | 31 +++
 rtl/i2c_slave_core.sv | 129 ++++++++++++
 rtl/i2c_gpio_port.sv | 72 +++++++
 tb/tb_i2c_gpio_port.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_bus_pkg.sv
// Shared i2c_frontend bus bundle layout and slave FSM state type.
// Used by i2c_frontend, pwm_i2c and i2c_gpio_port.
package i2c_bus_pkg;

   localparam int unsigned RX_W = 20;
   localparam int unsigned TX_W = 2;

   localparam int unsigned RX_BYTE_LSB    = 0;
   localparam int unsigned RX_BYTE_MSB    = 7;
   localparam int unsigned RX_BYTE_STROBE = 8;
   localparam int unsigned RX_ADDR_PHASE  = 9;
   localparam int unsigned RX_START       = 10;
   localparam int unsigned RX_STOP        = 11;
   localparam int unsigned RX_RW          = 12;
   localparam int unsigned RX_BIT_IDX_LSB = 13;
   localparam int unsigned RX_ACK_SLOT    = 16;
   localparam int unsigned RX_READ_SLOT   = 17;
   localparam int unsigned RX_PAD_LSB     = 18;
   localparam int unsigned RX_PAD_MSB     = 19;

   localparam int unsigned TX_ACK      = 0;
   localparam int unsigned TX_DATA_LOW = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_POINTER,
      ST_WRITE,
      ST_READ
   } slave_state_t;

endpackage

// File: rtl/i2c_slave_core.sv
// Generic register-pointer I2C slave: address match, transfer FSM,
// ACK / read-bit driving and register write strobes.
module i2c_slave_core
   import i2c_bus_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h22
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RX_W-1:0] i2c_interface_rx,
   input  logic [7:0]      rd_data,
   output logic [TX_W-1:0] i2c_interface_tx,
   output logic [1:0]      ptr,
   output logic            wr_en,
   output logic [7:0]      wr_data
);

   slave_state_t state_q, state_d;
   logic       sel_q, sel_d;
   logic       addr_ack_q, addr_ack_d;
   logic       ack_q;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] shift_q, shift_d;
   logic       load;

   logic [7:0] rx_byte;
   logic       strobe, addr_phase, start, stop, ack_slot, read_slot;
   logic [2:0] bit_idx;
   logic       addr_hit, ack_fall;
   logic       rx_unused;

   assign rx_byte    = i2c_interface_rx[RX_BYTE_MSB:RX_BYTE_LSB];
   assign strobe     = i2c_interface_rx[RX_BYTE_STROBE];
   assign addr_phase = i2c_interface_rx[RX_ADDR_PHASE];
   assign start      = i2c_interface_rx[RX_START];
   assign stop       = i2c_interface_rx[RX_STOP];
   assign bit_idx    = i2c_interface_rx[RX_BIT_IDX_LSB +: 3];
   assign ack_slot   = i2c_interface_rx[RX_ACK_SLOT];
   assign read_slot  = i2c_interface_rx[RX_READ_SLOT];
   assign rx_unused  = &{1'b0, i2c_interface_rx[RX_RW],
                         i2c_interface_rx[RX_PAD_MSB:RX_PAD_LSB]};

   assign addr_hit = strobe && addr_phase && (rx_byte[7:1] == I2C_ADDR);
   assign ack_fall = ack_q && !ack_slot;

   assign ptr     = ptr_q;
   assign wr_data = rx_byte;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      addr_ack_d = addr_ack_q;
      ptr_d      = ptr_q;
      shift_d    = shift_q;
      wr_en      = 1'b0;
      load       = 1'b0;

      if (start || stop) begin
         state_d    = ST_IDLE;
         sel_d      = 1'b0;
         addr_ack_d = 1'b0;
      end else begin
         if (ack_fall)
            addr_ack_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (addr_hit) begin
                  sel_d      = 1'b1;
                  addr_ack_d = 1'b1;
                  if (rx_byte[0]) begin
                     state_d = ST_READ;
                     load    = 1'b1;
                  end else begin
                     state_d = ST_POINTER;
                  end
               end
            end
            ST_POINTER: begin
               if (strobe) begin
                  ptr_d   = rx_byte[1:0];
                  state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (strobe) begin
                  wr_en = 1'b1;
                  ptr_d = ptr_q + 2'd1;
               end
            end
            ST_READ: begin
               // The address byte's own ack slot must not trigger a reload.
               if (ack_fall && !addr_ack_q)
                  load = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (load) begin
         shift_d = rd_data;
         ptr_d   = ptr_q + 2'd1;
      end

      i2c_interface_tx = '0;
      i2c_interface_tx[TX_ACK] = sel_q && ack_slot &&
         (state_q == ST_POINTER || state_q == ST_WRITE || addr_ack_q);
      i2c_interface_tx[TX_DATA_LOW] = sel_q && read_slot &&
         (state_q == ST_READ) && !shift_q[bit_idx];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         addr_ack_q <= 1'b0;
         ack_q      <= 1'b0;
         ptr_q      <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         addr_ack_q <= addr_ack_d;
         ack_q      <= ack_slot;
         ptr_q      <= ptr_d;
         shift_q    <= shift_d;
      end
   end

endmodule

// File: rtl/i2c_gpio_port.sv
// I2C-addressable 8-bit GPIO: OUT / DIR / IN / ID registers behind the
// shared slave core, with a 2-FF input synchronizer.
module i2c_gpio_port
   import i2c_bus_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h22,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [RX_W-1:0] i2c_interface_rx,
   output logic [TX_W-1:0] i2c_interface_tx,
   output logic [7:0]      gpio_out,
   output logic [7:0]      gpio_oe,
   input  logic [7:0]      gpio_in
);

   logic [7:0] out_q, dir_q, sync1_q, sync2_q;
   logic [7:0] rd_data, wr_data;
   logic [1:0] ptr;
   logic       wr_en;
   logic [TX_W-1:0] core_tx;

   i2c_slave_core #(
      .I2C_ADDR(I2C_ADDR)
   ) u_core (
      .clk              (clk),
      .reset            (reset),
      .i2c_interface_rx (i2c_interface_rx),
      .rd_data          (rd_data),
      .i2c_interface_tx (core_tx),
      .ptr              (ptr),
      .wr_en            (wr_en),
      .wr_data          (wr_data)
   );

   // Other slaves on this frontend would be ORed in here.
   assign i2c_interface_tx = core_tx;

   always_comb begin
      rd_data = '0;
      case (ptr)
         2'd0:    rd_data = out_q;
         2'd1:    rd_data = dir_q;
         2'd2:    rd_data = sync2_q;
         default: rd_data = ID_VALUE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q   <= '0;
         dir_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
         if (wr_en) begin
            case (ptr)
               2'd0:    out_q <= wr_data;
               2'd1:    dir_q <= wr_data;
               default: ;
            endcase
         end
      end
   end

   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_i2c_gpio_port.sv
// Directed bench for i2c_gpio_port: drives the frontend rx bundle by hand
// and checks ACKs, read bits and GPIO register effects.
module tb_i2c_gpio_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [19:0] rx;
   logic [1:0]  tx;
   logic [7:0]  gpio_out, gpio_oe, gpio_in;

   logic [7:0] byte_v;
   logic       strobe, addr_phase, start_s, stop_s, rw, ack_slot, rd_slot;
   logic [2:0] bit_idx;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   assign rx = {2'b00, rd_slot, ack_slot, bit_idx, rw, stop_s, start_s,
                addr_phase, strobe, byte_v};

   i2c_gpio_port #(
      .I2C_ADDR(7'h22),
      .ID_VALUE(8'hA5)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .i2c_interface_rx (rx),
      .i2c_interface_tx (tx),
      .gpio_out         (gpio_out),
      .gpio_oe          (gpio_oe),
      .gpio_in          (gpio_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic bus_start();
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      @(negedge clk);
   endtask

   task automatic bus_stop();
      stop_s = 1'b1;
      @(negedge clk);
      stop_s = 1'b0;
      @(negedge clk);
   endtask

   // Byte from master, followed by the slave's ack slot; returns tx[0] there.
   task automatic send_byte(input logic [7:0] b, input logic ap, output logic acked);
      byte_v     = b;
      addr_phase = ap;
      if (ap) rw = b[0];
      strobe     = 1'b1;
      @(negedge clk);
      strobe     = 1'b0;
      addr_phase = 1'b0;
      @(negedge clk);
      ack_slot = 1'b1;
      #1 acked = tx[0];
      @(negedge clk);
      ack_slot = 1'b0;
      @(negedge clk);
   endtask

   // Byte from slave (SDA = ~data_low), then the master's ack slot.
   task automatic read_byte(input logic [7:0] pin_change, output logic [7:0] d,
                            output logic slave_ack);
      for (int i = 7; i >= 0; i--) begin
         bit_idx = 3'(i);
         rd_slot = 1'b1;
         #1 d[i] = ~tx[1];
         @(negedge clk);
         rd_slot = 1'b0;
         if (i == 4) gpio_in = pin_change;
         @(negedge clk);
      end
      ack_slot = 1'b1;
      #1 slave_ack = tx[0];
      @(negedge clk);
      ack_slot = 1'b0;
      @(negedge clk);
   endtask

   logic       a;
   logic [7:0] d;
   logic [2:0] top3;

   initial begin
      reset = 1'b0;
      byte_v = '0; strobe = 0; addr_phase = 0; start_s = 0; stop_s = 0;
      rw = 0; ack_slot = 0; rd_slot = 0; bit_idx = '0; gpio_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_out", gpio_out, 8'h00);
      check("rst_oe", gpio_oe, 8'h00);
      check("rst_tx", 8'(tx), 8'h00);
      reset = 1'b1;
      @(negedge clk);

      // Plain write of OUT
      bus_start();
      send_byte(8'h44, 1'b1, a); check("w1_addr_ack", 8'(a), 8'h01);
      send_byte(8'h00, 1'b0, a); check("w1_ptr_ack", 8'(a), 8'h01);
      send_byte(8'h5A, 1'b0, a); check("w1_data_ack", 8'(a), 8'h01);
      check("w1_out", gpio_out, 8'h5A);
      check("w1_oe", gpio_oe, 8'h00);
      bus_stop();

      // Pointer wraps from ID (ignored) to OUT
      bus_start();
      send_byte(8'h44, 1'b1, a); check("w2_addr_ack", 8'(a), 8'h01);
      send_byte(8'h03, 1'b0, a); check("w2_ptr_ack", 8'(a), 8'h01);
      send_byte(8'h11, 1'b0, a); check("w2_id_ack", 8'(a), 8'h01);
      send_byte(8'h22, 1'b0, a); check("w2_out_ack", 8'(a), 8'h01);
      bus_stop();
      check("w2_out", gpio_out, 8'h22);
      check("w2_oe", gpio_oe, 8'h00);

      // DIR write
      bus_start();
      send_byte(8'h44, 1'b1, a);
      send_byte(8'h01, 1'b0, a);
      send_byte(8'hF0, 1'b0, a); check("w3_dir_ack", 8'(a), 8'h01);
      bus_stop();
      check("w3_oe", gpio_oe, 8'hF0);
      check("w3_out", gpio_out, 8'h22);

      // Read IN then ID; pins change mid-byte without corrupting it
      gpio_in = 8'h3C;
      bus_start();
      send_byte(8'h44, 1'b1, a);
      send_byte(8'h02, 1'b0, a); check("r_ptr_ack", 8'(a), 8'h01);
      bus_start();
      send_byte(8'h45, 1'b1, a); check("r_addr_ack", 8'(a), 8'h01);
      read_byte(8'h00, d, a);
      check("r_in_byte", d, 8'h3C);
      check("r_no_ack1", 8'(a), 8'h00);
      read_byte(8'h00, d, a);
      check("r_id_byte", d, 8'hA5);
      check("r_no_ack2", 8'(a), 8'h00);
      bus_stop();
      check("r_idle_tx", 8'(tx), 8'h00);

      // Foreign address
      bus_start();
      send_byte(8'h46, 1'b1, a); check("mm_addr_ack", 8'(a), 8'h00);
      send_byte(8'h99, 1'b0, a); check("mm_data_ack", 8'(a), 8'h00);
      bus_stop();
      check("mm_out", gpio_out, 8'h22);
      check("mm_oe", gpio_oe, 8'hF0);

      // Start inside WRITE, then foreign address
      bus_start();
      send_byte(8'h44, 1'b1, a);
      send_byte(8'h00, 1'b0, a);
      bus_start();
      send_byte(8'h46, 1'b1, a); check("sw_addr_ack", 8'(a), 8'h00);
      send_byte(8'h77, 1'b0, a); check("sw_data_ack", 8'(a), 8'h00);
      bus_stop();
      check("sw_out", gpio_out, 8'h22);

      // Reset during bit 4 of an OUT (0x22) read
      bus_start();
      send_byte(8'h44, 1'b1, a);
      send_byte(8'h00, 1'b0, a);
      bus_start();
      send_byte(8'h45, 1'b1, a);
      for (int i = 7; i >= 5; i--) begin
         bit_idx = 3'(i);
         rd_slot = 1'b1;
         #1 top3[i-5] = ~tx[1];
         @(negedge clk);
         rd_slot = 1'b0;
         @(negedge clk);
      end
      check("rr_top3", 8'(top3), 8'h01);
      bit_idx = 3'd4;
      rd_slot = 1'b1;
      #1 check("rr_bit4_tx", 8'(tx), 8'h02);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("rr_tx", 8'(tx), 8'h00);
      check("rr_out", gpio_out, 8'h00);
      check("rr_oe", gpio_oe, 8'h00);
      rd_slot = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      bus_start();
      send_byte(8'h44, 1'b1, a); check("rr_w_addr_ack", 8'(a), 8'h01);
      send_byte(8'h01, 1'b0, a);
      send_byte(8'h0F, 1'b0, a); check("rr_w_data_ack", 8'(a), 8'h01);
      bus_stop();
      check("rr_w_oe", gpio_oe, 8'h0F);
      check("rr_w_out", gpio_out, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
